cache_mem_arbiter: RTL and testbench

//  Shares one Wishbone-style physical memory port between the I-cache and D-cache controllers.

---
 rtl/cache_mem_arbiter_pkg.sv | 34 +++
 rtl/cache_mem_arbiter_if.sv | 54 +++++
 rtl/cache_mem_arbiter_watchdog.sv | 44 ++++
 rtl/cache_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter_pkg
// Shared types and constants for the I/D-cache to memory arbiter on the lc3b
// CPU top level: bus widths, line/word/select types, arbiter state encodings
// and the round-robin owner type.
// No ports (package).
// -----------------------------------------------------------------------------
package cache_mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int SEL_W  = LINE_W / 8;

  typedef logic [ADDR_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [SEL_W-1:0]  lc3b_sel;

  // State encoding doubles as the grant vector: 01 = I owns memory, 10 = D.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GNT_I = 2'b01;
  localparam logic [1:0] ST_GNT_D = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = ST_IDLE,
    ARB_GNT_I = ST_GNT_I,
    ARB_GNT_D = ST_GNT_D
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces used by cache_mem_arbiter.
//  cache_mem_arbiter_if     : one cache_control master <-> arbiter link
//    master drives cyc/stb/we/adr/dat_w/sel, slave returns ack/err/dat_r
//  cache_mem_arbiter_mem_if : arbiter <-> physical memory link
//    master drives cyc/stb/we/adr/dat_w/sel, slave returns ack/dat_r
//    (memory has no error signal; aborts come from the arbiter watchdog)
// -----------------------------------------------------------------------------
interface cache_mem_arbiter_if;
  import cache_mem_arbiter_pkg::*;

  logic     cyc;
  logic     stb;
  logic     we;
  lc3b_word adr;
  lc3b_line dat_w;
  lc3b_sel  sel;
  logic     ack;
  logic     err;
  lc3b_line dat_r;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, err, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, err, dat_r
  );
endinterface

interface cache_mem_arbiter_mem_if;
  import cache_mem_arbiter_pkg::*;

  logic     cyc;
  logic     stb;
  logic     we;
  lc3b_word adr;
  lc3b_line dat_w;
  lc3b_sel  sel;
  logic     ack;
  lc3b_line dat_r;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, dat_r
  );
endinterface

// File: rtl/cache_mem_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
// Counts grant cycles that pass without a memory ack and flags the cycle in
// which the count reaches TIMEOUT, so the arbiter can abort a stuck transfer.
// TIMEOUT = 0 disables the watchdog (expired never asserts).
// Ports:
//  clk     in  clock
//  rst     in  synchronous active-high reset
//  clear   in  zero the count (asserted on every grant change)
//  run     in  a grant cycle without ack; count advances
//  expired out combinational: this run cycle is cycle TIMEOUT of the grant
// -----------------------------------------------------------------------------
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Count is 0 in the first grant cycle, so cycle TIMEOUT sees TIMEOUT-1.
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  logic [CNT_W-1:0] r_count;

  // Stall counter; saturates so a disabled watchdog never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (run && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign expired = (TIMEOUT > 0) && run && (r_count == LIMIT);

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one Wishbone-style memory port between the I-cache and D-cache
// controllers. One master is granted at a time (round-robin on ties), its
// request is forwarded to memory and ack/err are routed back to it only.
// Ports:
//  clk      in   clock, all state on posedge
//  rst      in   synchronous active-high reset
//  ic_bus   slave  I-cache request in, ack/err/dat_r out
//  dc_bus   slave  D-cache request in, ack/err/dat_r out
//  mem_bus  master request to memory, ack/dat_r from memory
//  o_grant  out  01 = I owns memory, 10 = D, 00 = none
// -----------------------------------------------------------------------------
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_mem_arbiter_if.slave      ic_bus,
  cache_mem_arbiter_if.slave      dc_bus,
  cache_mem_arbiter_mem_if.master mem_bus,
  output logic [1:0]              o_grant
);

  logic [1:0] r_state;
  arb_owner_t r_last;
  logic [1:0] w_next;

  logic w_req_i;
  logic w_req_d;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_own_cyc;
  logic w_own_stb;
  logic w_wd_run;
  logic w_wd_clear;
  logic w_expired;

  assign w_req_i = ic_bus.cyc & ic_bus.stb;
  assign w_req_d = dc_bus.cyc & dc_bus.stb;
  assign w_gnt_i = (r_state == ST_GNT_I);
  assign w_gnt_d = (r_state == ST_GNT_D);

  assign w_own_cyc = (w_gnt_i & ic_bus.cyc) | (w_gnt_d & dc_bus.cyc);
  assign w_own_stb = (w_gnt_i & ic_bus.stb) | (w_gnt_d & dc_bus.stb);

  // The watchdog only ages a live transfer; an ack in the same cycle wins.
  assign w_wd_run   = w_own_cyc & ~mem_bus.ack;
  assign w_wd_clear = (w_next != r_state);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_wd_clear),
    .run     (w_wd_run),
    .expired (w_expired)
  );

  // Next-state logic: arbitration in IDLE, completion/abandon/abort in GNT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_i && w_req_d) begin
          // Tie: whoever was not granted last wins.
          if (r_last == OWN_D) begin
            w_next = ST_GNT_I;
          end else begin
            w_next = ST_GNT_D;
          end
        end else if (w_req_i) begin
          w_next = ST_GNT_I;
        end else if (w_req_d) begin
          w_next = ST_GNT_D;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_GNT_I: begin
        if (mem_bus.ack) begin
          // Hand straight over to a waiting D; I must pass IDLE to re-win.
          w_next = w_req_d ? ST_GNT_D : ST_IDLE;
        end else if (!ic_bus.cyc || w_expired) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_GNT_I;
        end
      end
      ST_GNT_D: begin
        if (mem_bus.ack) begin
          w_next = w_req_i ? ST_GNT_I : ST_IDLE;
        end else if (!dc_bus.cyc || w_expired) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_GNT_D;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register and round-robin pointer (reset to I so the first tie goes to D).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= OWN_I;
    end else begin
      r_state <= w_next;
      if (w_next == ST_GNT_I) begin
        r_last <= OWN_I;
      end else if (w_next == ST_GNT_D) begin
        r_last <= OWN_D;
      end else begin
        r_last <= r_last;
      end
    end
  end

  // Memory side: owner's request, dropped in the abort cycle.
  // Address/data/select default to D when idle (don't-care there).
  assign mem_bus.cyc   = w_own_cyc & ~w_expired;
  assign mem_bus.stb   = w_own_stb & ~w_expired;
  assign mem_bus.we    = (w_gnt_i & ic_bus.we) | (w_gnt_d & dc_bus.we);
  assign mem_bus.adr   = w_gnt_i ? ic_bus.adr   : dc_bus.adr;
  assign mem_bus.dat_w = w_gnt_i ? ic_bus.dat_w : dc_bus.dat_w;
  assign mem_bus.sel   = w_gnt_i ? ic_bus.sel   : dc_bus.sel;

  // Master side: ack/err only to the owner; read data broadcast.
  assign ic_bus.ack   = w_gnt_i & mem_bus.ack;
  assign dc_bus.ack   = w_gnt_d & mem_bus.ack;
  assign ic_bus.err   = w_gnt_i & w_expired;
  assign dc_bus.err   = w_gnt_d & w_expired;
  assign ic_bus.dat_r = mem_bus.dat_r;
  assign dc_bus.dat_r = mem_bus.dat_r;

  assign o_grant = r_state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Directed bench: expected memory transfers are queued as requests are raised
// and popped as the arbiter presents them to memory; each completion checks
// ack routing and read data. Inputs change and outputs are sampled between
// the negative edge and the next rising edge.
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;

  cache_mem_arbiter_if     ic_bus ();
  cache_mem_arbiter_if     dc_bus ();
  cache_mem_arbiter_mem_if mem_bus ();

  cache_mem_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ic_bus  (ic_bus),
    .dc_bus  (dc_bus),
    .mem_bus (mem_bus),
    .o_grant (grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] gnt;
    lc3b_word   adr;
    logic       we;
    lc3b_line   dat;
    lc3b_sel    sel;
  } xfer_t;

  xfer_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic req_i(input lc3b_word a, input logic w, input lc3b_line d, input lc3b_sel s, input bit push);
    ic_bus.cyc = 1'b1; ic_bus.stb = 1'b1; ic_bus.we = w;
    ic_bus.adr = a; ic_bus.dat_w = d; ic_bus.sel = s;
    if (push) sb.push_back('{gnt: 2'b01, adr: a, we: w, dat: d, sel: s});
  endtask

  task automatic req_d(input lc3b_word a, input logic w, input lc3b_line d, input lc3b_sel s, input bit push);
    dc_bus.cyc = 1'b1; dc_bus.stb = 1'b1; dc_bus.we = w;
    dc_bus.adr = a; dc_bus.dat_w = d; dc_bus.sel = s;
    if (push) sb.push_back('{gnt: 2'b10, adr: a, we: w, dat: d, sel: s});
  endtask

  task automatic drop_i();
    ic_bus.cyc = 1'b0; ic_bus.stb = 1'b0; ic_bus.we = 1'b0;
  endtask

  task automatic drop_d();
    dc_bus.cyc = 1'b0; dc_bus.stb = 1'b0; dc_bus.we = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    drop_i(); drop_d();
    mem_bus.ack = 1'b0;
    tick();
    tick();
    #1;
    rst = 1'b0;
  endtask

  // Wait (bounded) for the next transfer on memory, check it against the queue
  // head, hold for lat cycles, ack it and check routing; owner then drops.
  task automatic serve(input int lat, output int waited);
    xfer_t    e;
    lc3b_line rd;
    waited = 0;
    chk("sb_nonempty", (sb.size() > 0), 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      while (mem_bus.stb !== 1'b1 && waited < 32) begin
        tick(); #1; waited++;
      end
      chk("stb_seen", mem_bus.stb, 1'b1);
      chk("grant", grant, e.gnt);
      chk("mem_adr", mem_bus.adr, e.adr);
      chk("mem_we", mem_bus.we, e.we);
      chk("mem_sel", mem_bus.sel, e.sel);
      if (e.we) chk("mem_dat_w", mem_bus.dat_w, e.dat);
      for (int k = 0; k < lat; k++) begin
        tick(); #1;
        chk("hold_grant", grant, e.gnt);
        chk("no_early_ack", {ic_bus.ack, dc_bus.ack}, 2'b00);
      end
      tick();
      rd = {$urandom, $urandom, $urandom, $urandom};
      mem_bus.dat_r = rd;
      mem_bus.ack   = 1'b1;
      #1;
      chk("ack_i", ic_bus.ack, e.gnt[0]);
      chk("ack_d", dc_bus.ack, e.gnt[1]);
      chk("no_err", {ic_bus.err, dc_bus.err}, 2'b00);
      chk("dat_r", e.gnt[0] ? ic_bus.dat_r : dc_bus.dat_r, rd);
      tick();
      mem_bus.ack = 1'b0;
      if (e.gnt[0]) drop_i(); else drop_d();
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int w;
    lc3b_line a5;
    a5 = {16{8'hA5}};
    rst = 1'b1;
    drop_i(); drop_d();
    ic_bus.adr = 16'h0000; ic_bus.dat_w = '0; ic_bus.sel = 16'h0000;
    dc_bus.adr = 16'h0000; dc_bus.dat_w = '0; dc_bus.sel = 16'h0000;
    mem_bus.ack = 1'b0; mem_bus.dat_r = '0;

    // Reset state
    do_reset();
    chk("rst_grant", grant, 2'b00);
    chk("rst_outs", {mem_bus.cyc, mem_bus.stb, mem_bus.we, ic_bus.ack, dc_bus.ack, ic_bus.err, dc_bus.err}, 7'b0);

    // I alone, 1-cycle arbitration latency, ack in cycle 4
    req_i(16'h1230, 1'b0, '0, 16'hFFFF, 1'b1);
    #1;
    chk("i_req_idle_grant", grant, 2'b00);
    chk("i_req_idle_stb", mem_bus.stb, 1'b0);
    serve(1, w);
    chk("i_latency", w, 1);
    chk("i_done_idle", grant, 2'b00);

    // Ties after reset: D, then I back-to-back, third tie D again
    do_reset();
    req_d(16'h2000, 1'b0, '0, 16'hFFFF, 1'b1);
    req_i(16'h1000, 1'b0, '0, 16'hFFFF, 1'b1);
    #1;
    serve(0, w);
    chk("tie_d_latency", w, 1);
    serve(0, w);
    chk("b2b_no_bubble", w, 0);
    chk("tie_done_idle", grant, 2'b00);
    req_d(16'h2010, 1'b0, '0, 16'h00FF, 1'b1);
    req_i(16'h1010, 1'b0, '0, 16'hFF00, 1'b1);
    #1;
    serve(0, w);
    serve(0, w);
    chk("tie3_b2b", w, 0);

    // D write while I waits
    req_d(16'h2200, 1'b1, a5, 16'hFFFF, 1'b1);
    req_i(16'h1240, 1'b0, {4{32'h5A5A_1234}}, 16'h0F0F, 1'b1);
    #1;
    serve(2, w);
    serve(1, w);
    chk("wr_i_b2b", w, 0);

    // Watchdog: I never acked, err on grant cycle TO, D pending afterwards
    req_i(16'h3000, 1'b0, '0, 16'hFFFF, 1'b0);
    #1;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k == 3) req_d(16'h3100, 1'b0, '0, 16'hFFFF, 1'b1);
      #1;
      chk("to_grant", grant, 2'b01);
      chk("to_d_quiet", {dc_bus.ack, dc_bus.err}, 2'b00);
      if (k < TO) begin
        chk("to_err_early", ic_bus.err, 1'b0);
        chk("to_stb_live", mem_bus.stb, 1'b1);
      end else begin
        chk("to_err_pulse", ic_bus.err, 1'b1);
        chk("to_stb_drop", {mem_bus.cyc, mem_bus.stb}, 2'b00);
      end
    end
    tick();
    drop_i();
    #1;
    chk("to_then_idle", grant, 2'b00);
    chk("to_err_single", ic_bus.err, 1'b0);
    serve(0, w);
    chk("to_d_latency", w, 1);

    // I abandons mid-grant; stray ack in IDLE
    req_i(16'h4000, 1'b0, '0, 16'hFFFF, 1'b0);
    tick(); #1;
    chk("ab_grant", grant, 2'b01);
    tick();
    drop_i();
    #1;
    chk("ab_no_resp", {ic_bus.ack, ic_bus.err, mem_bus.cyc}, 3'b000);
    tick(); #1;
    chk("ab_idle", grant, 2'b00);
    tick();
    mem_bus.ack = 1'b1;
    #1;
    chk("stray_ack", {ic_bus.ack, dc_bus.ack, mem_bus.cyc}, 3'b000);
    tick();
    mem_bus.ack = 1'b0;
    #1;
    chk("stray_idle", grant, 2'b00);

    // Reset during a D write grant
    req_d(16'h5000, 1'b1, a5, 16'hFFFF, 1'b0);
    tick(); #1;
    chk("rg_grant", grant, 2'b10);
    chk("rg_live", {mem_bus.stb, mem_bus.we}, 2'b11);
    tick();
    rst = 1'b1;
    #1;
    tick();
    drop_d();
    #1;
    chk("rg_grant0", grant, 2'b00);
    chk("rg_outs", {mem_bus.cyc, mem_bus.stb, mem_bus.we, ic_bus.ack, dc_bus.ack, ic_bus.err, dc_bus.err}, 7'b0);
    tick();
    rst = 1'b0;
    req_d(16'h6000, 1'b0, '0, 16'hFFFF, 1'b1);
    req_i(16'h6100, 1'b0, '0, 16'hFFFF, 1'b1);
    #1;
    serve(0, w);
    chk("post_rst_tie_d", w, 1);
    serve(0, w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
